// File: rtl/imm_gen_pipe_pkg.sv
// Shared LC-3b immediate-generator types: instruction word, immediate select
// modes and the raw field widths used by the extension logic.
package imm_gen_pipe_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    SEL_OFF6_SH  = 3'd0,
    SEL_OFF9_SH  = 3'd1,
    SEL_OFF11_SH = 3'd2,
    SEL_IMM5     = 3'd3,
    SEL_IMM4     = 3'd4,
    SEL_OFF6     = 3'd5,
    SEL_TRAP8_SH = 3'd6,
    SEL_RSVD     = 3'd7
  } imm_sel_t;

  localparam int IMM4_W  = 4;
  localparam int IMM5_W  = 5;
  localparam int OFF6_W  = 6;
  localparam int OFF9_W  = 9;
  localparam int OFF11_W = 11;
  localparam int TRAP8_W = 8;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extraction/extension: picks the field selected by
// sel, sign- or zero-extends it to WIDTH and applies the optional <<1.
module imm_ext_core
  import imm_gen_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  lc3b_word         ir,
  input  imm_sel_t         sel,
  output logic [WIDTH-1:0] imm,
  output logic             err
);

  // Sign always comes from the field MSB before the shift is applied.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel)
      SEL_OFF6_SH:  imm = {{(WIDTH-OFF6_W-1){ir[OFF6_W-1]}}, ir[OFF6_W-1:0], 1'b0};
      SEL_OFF9_SH:  imm = {{(WIDTH-OFF9_W-1){ir[OFF9_W-1]}}, ir[OFF9_W-1:0], 1'b0};
      SEL_OFF11_SH: imm = {{(WIDTH-OFF11_W-1){ir[OFF11_W-1]}}, ir[OFF11_W-1:0], 1'b0};
      SEL_IMM5:     imm = {{(WIDTH-IMM5_W){ir[IMM5_W-1]}}, ir[IMM5_W-1:0]};
      SEL_IMM4:     imm = {{(WIDTH-IMM4_W){ir[IMM4_W-1]}}, ir[IMM4_W-1:0]};
      SEL_OFF6:     imm = {{(WIDTH-OFF6_W){ir[OFF6_W-1]}}, ir[OFF6_W-1:0]};
      SEL_TRAP8_SH: imm = {{(WIDTH-TRAP8_W-1){1'b0}}, ir[TRAP8_W-1:0], 1'b0};
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined LC-3b immediate generator: combinational extension followed by a
// STAGES-deep elastic valid/ready register chain carrying {imm, tag, err}.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_ir,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [WIDTH-1:0] ext_imm;
  logic             ext_err;

  imm_ext_core #(.WIDTH(WIDTH)) u_ext (
    .ir  (in_ir),
    .sel (imm_sel_t'(in_sel)),
    .imm (ext_imm),
    .err (ext_err)
  );

  logic [STAGES-1:0] stage_valid;
  logic [WIDTH-1:0]  stage_imm [STAGES];
  logic [TAG_W-1:0]  stage_tag [STAGES];
  logic [STAGES-1:0] stage_err;
  logic [STAGES:0]   room;

  // room[k]: stage k can take a new item this cycle (it is empty or its item
  // moves on). Built only from registered valids and out_ready.
  always_comb begin
    room         = '0;
    room[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room[k] = ~stage_valid[k] | room[k+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_imm;
    logic [TAG_W-1:0] up_tag;
    logic             up_err;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] imm_d, imm_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic             err_d, err_q;

    if (gi == 0) begin : g_src_in
      assign up_valid = in_valid;
      assign up_imm   = ext_imm;
      assign up_tag   = in_tag;
      assign up_err   = ext_err;
    end else begin : g_src_prev
      assign up_valid = stage_valid[gi-1];
      assign up_imm   = stage_imm[gi-1];
      assign up_tag   = stage_tag[gi-1];
      assign up_err   = stage_err[gi-1];
    end

    // Data only loads with a valid item; flush overrides any load.
    always_comb begin
      valid_d = valid_q;
      imm_d   = imm_q;
      tag_d   = tag_q;
      err_d   = err_q;
      if (room[gi]) begin
        valid_d = up_valid;
        if (up_valid) begin
          imm_d = up_imm;
          tag_d = up_tag;
          err_d = up_err;
        end
      end
      if (flush) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        tag_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= valid_d;
        imm_q   <= imm_d;
        tag_q   <= tag_d;
        err_q   <= err_d;
      end
    end

    assign stage_valid[gi] = valid_q;
    assign stage_imm[gi]   = imm_q;
    assign stage_tag[gi]   = tag_q;
    assign stage_err[gi]   = err_q;
  end

  assign in_ready  = room[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_imm   = stage_imm[STAGES-1];
  assign out_tag   = stage_tag[STAGES-1];
  assign out_err   = stage_err[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (16b/1 stage, 32b/2 stages,
// 20b/3 stages) with directed cases plus a randomized scoreboard run.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_ir     [3];
  logic [2:0]  in_sel    [3];
  logic [3:0]  in_tag    [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [3:0]  out_tag   [3];
  logic        out_err   [3];
  logic [31:0] out_imm   [3];
  logic [15:0] imm0;
  logic [31:0] imm1;
  logic [19:0] imm2;

  assign out_imm[0] = 32'(imm0);
  assign out_imm[1] = imm1;
  assign out_imm[2] = 32'(imm2);

  imm_gen_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ir(in_ir[0]),
    .in_sel(in_sel[0]), .in_tag(in_tag[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_imm(imm0), .out_tag(out_tag[0]), .out_err(out_err[0]));

  imm_gen_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ir(in_ir[1]),
    .in_sel(in_sel[1]), .in_tag(in_tag[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_imm(imm1), .out_tag(out_tag[1]), .out_err(out_err[1]));

  imm_gen_pipe #(.WIDTH(20), .STAGES(3), .TAG_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_ir(in_ir[2]),
    .in_sel(in_sel[2]), .in_tag(in_tag[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_imm(imm2), .out_tag(out_tag[2]), .out_err(out_err[2]));

  typedef struct packed {
    logic [31:0] imm;
    logic [3:0]  tag;
    logic        err;
  } item_t;

  int n_cmp = 0;
  int n_bad = 0;
  int emitted [3] = '{0, 0, 0};
  int sb_cnt  [3] = '{0, 0, 0};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int stg(input int d);
    return d + 1;
  endfunction

  function automatic int wid(input int d);
    return (d == 0) ? 16 : (d == 1) ? 32 : 20;
  endfunction

  // Reference: field length, shift and signedness per mode, then plain integer math.
  function automatic item_t ref_item(input logic [15:0] ir, input logic [2:0] sel,
                                     input logic [3:0] tag, input int width);
    item_t  it;
    int     n;
    bit     sh, sx;
    longint f;
    it.tag = tag;
    it.err = 1'b0;
    it.imm = '0;
    n = 1; sh = 0; sx = 0;
    case (sel)
      3'd0: begin n = 6;  sh = 1; sx = 1; end
      3'd1: begin n = 9;  sh = 1; sx = 1; end
      3'd2: begin n = 11; sh = 1; sx = 1; end
      3'd3: begin n = 5;  sh = 0; sx = 1; end
      3'd4: begin n = 4;  sh = 0; sx = 1; end
      3'd5: begin n = 6;  sh = 0; sx = 1; end
      3'd6: begin n = 8;  sh = 1; sx = 0; end
      default: it.err = 1'b1;
    endcase
    if (!it.err) begin
      f = longint'(ir) % (longint'(1) << n);
      if (sx && f >= (longint'(1) << (n - 1))) f = f - (longint'(1) << n);
      if (sh) f = f * 2;
      it.imm = 32'(f & ((longint'(1) << width) - 1));
    end
    return it;
  endfunction

  // Per-configuration scoreboard: consume first, then flush/accept.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    item_t sb[$];
    always @(negedge clk) begin
      item_t e;
      if (!rst_n) begin
        sb.delete();
      end else begin
        if (out_valid[gi] && out_ready[gi]) begin
          emitted[gi]++;
          if (sb.size() == 0) begin
            check_eq($sformatf("d%0d_spurious_out", gi), 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            check_eq($sformatf("d%0d_imm", gi), 64'(out_imm[gi]), 64'(e.imm));
            check_eq($sformatf("d%0d_tag", gi), 64'(out_tag[gi]), 64'(e.tag));
            check_eq($sformatf("d%0d_err", gi), 64'(out_err[gi]), 64'(e.err));
            $display("d%0d out tag=%0d imm=0x%0h err=%0b", gi, out_tag[gi], out_imm[gi], out_err[gi]);
          end
        end
        if (flush) sb.delete();
        else if (in_valid[gi] && in_ready[gi])
          sb.push_back(ref_item(in_ir[gi], in_sel[gi], in_tag[gi], wid(gi)));
      end
      sb_cnt[gi] = sb.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      in_ir[d] = '0; in_sel[d] = '0; in_tag[d] = '0;
    end
  endtask

  task automatic drive(input int d, input logic [15:0] ir, input logic [2:0] sel, input logic [3:0] tag);
    in_valid[d] = 1'b1; in_ir[d] = ir; in_sel[d] = sel; in_tag[d] = tag;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    while (sb_cnt[d] != 0 && n < 20) begin tick(); n++; end
    tick();
    check_eq($sformatf("d%0d_drained", d), 64'(sb_cnt[d]), 64'd0);
  endtask

  task automatic directed(input int d, input logic [15:0] ir, input logic [2:0] sel,
                          input logic [3:0] tag, input logic [31:0] exp_imm, input logic exp_err);
    int lat;
    check_eq($sformatf("d%0d_rdy_idle", d), 64'(in_ready[d]), 64'd1);
    drive(d, ir, sel, tag);
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 8) begin tick(); lat++; end
    check_eq($sformatf("d%0d_latency", d), 64'(lat), 64'(stg(d) - 1));
    check_eq($sformatf("d%0d_dir_imm", d), 64'(out_imm[d]), 64'(exp_imm));
    check_eq($sformatf("d%0d_dir_err", d), 64'(out_err[d]), 64'(exp_err));
    check_eq($sformatf("d%0d_dir_tag", d), 64'(out_tag[d]), 64'(tag));
    $display("d%0d directed ir=0x%04h sel=%0d imm=0x%0h err=%0b", d, ir, sel, out_imm[d], out_err[d]);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it1;
    logic [15:0] ir1;
    logic [2:0]  sel1;
    int base [3];

    rst_n = 1'b0; flush = 1'b0;
    idle_all();
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("d%0d_rst_valid", d), 64'(out_valid[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_imm", d), 64'(out_imm[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_tag", d), 64'(out_tag[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_err", d), 64'(out_err[d]), 64'd0);
      check_eq($sformatf("d%0d_rst_ready", d), 64'(in_ready[d]), 64'd1);
    end
    rst_n = 1'b1;
    tick();

    directed(0, 16'h003F, 3'd0, 4'd1, 32'h0000FFFE, 1'b0);
    directed(0, 16'h0100, 3'd1, 4'd2, 32'h0000FE00, 1'b0);
    directed(0, 16'h03FF, 3'd2, 4'd3, 32'h000007FE, 1'b0);
    directed(0, 16'h0010, 3'd3, 4'd4, 32'h0000FFF0, 1'b0);
    directed(0, 16'h0008, 3'd4, 4'd5, 32'h0000FFF8, 1'b0);
    directed(0, 16'h00FF, 3'd6, 4'd6, 32'h000001FE, 1'b0);
    directed(0, 16'h0020, 3'd5, 4'd7, 32'h0000FFE0, 1'b0);
    directed(0, 16'hFFFF, 3'd7, 4'd8, 32'h00000000, 1'b1);
    directed(1, 16'h0100, 3'd1, 4'd1, 32'hFFFFFE00, 1'b0);
    directed(1, 16'h00FF, 3'd6, 4'd2, 32'h000001FE, 1'b0);
    directed(1, 16'h1234, 3'd7, 4'd3, 32'h00000000, 1'b1);
    directed(2, 16'h0100, 3'd1, 4'd4, 32'h000FFE00, 1'b0);

    // Backpressure on the 2-stage pipe: tags 1,2 fill it, tag 3 waits.
    base[1] = emitted[1];
    out_ready[1] = 1'b0;
    ir1 = 16'($urandom); sel1 = 3'($urandom_range(0, 6));
    it1 = ref_item(ir1, sel1, 4'd1, 32);
    drive(1, ir1, sel1, 4'd1); tick();
    check_eq("bp_rdy_second", 64'(in_ready[1]), 64'd1);
    drive(1, 16'($urandom), 3'($urandom_range(0, 7)), 4'd2); tick();
    drive(1, 16'($urandom), 3'($urandom_range(0, 7)), 4'd3);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_stall_rdy", 64'(in_ready[1]), 64'd0);
      check_eq("bp_hold_valid", 64'(out_valid[1]), 64'd1);
      check_eq("bp_hold_tag", 64'(out_tag[1]), 64'd1);
      check_eq("bp_hold_imm", 64'(out_imm[1]), 64'(it1.imm));
      tick();
    end
    out_ready[1] = 1'b1;
    #1;
    check_eq("bp_release_rdy", 64'(in_ready[1]), 64'd1);
    tick();
    in_valid[1] = 1'b0;
    drain(1);
    check_eq("bp_count", 64'(emitted[1] - base[1]), 64'd3);

    // Streaming into the 3-stage pipe: 8 back-to-back items, out_ready held.
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        drive(2, 16'($urandom), 3'($urandom_range(0, 7)), 4'(j));
        check_eq("st_in_ready", 64'(in_ready[2]), 64'd1);
      end else begin
        in_valid[2] = 1'b0;
      end
      tick();
      check_eq("st_out_valid", 64'(out_valid[2]), 64'((j >= 2 && j <= 9) ? 1 : 0));
      if (j >= 2 && j <= 9) check_eq("st_out_tag", 64'(out_tag[2]), 64'(j - 2));
    end
    drain(2);

    // Flush with two items in flight; the empty pipe also drops its input.
    base[1] = emitted[1]; base[0] = emitted[0];
    out_ready[1] = 1'b0;
    drive(1, 16'($urandom), 3'd0, 4'd4); tick();
    drive(1, 16'($urandom), 3'd1, 4'd5); tick();
    drive(1, 16'($urandom), 3'd2, 4'd9);
    drive(0, 16'($urandom), 3'd3, 4'd9);
    flush = 1'b1;
    check_eq("fl_rdy_during", 64'(in_ready[0]), 64'd1);
    tick();
    flush = 1'b0; in_valid[1] = 1'b0; in_valid[0] = 1'b0;
    check_eq("fl_out_valid", 64'(out_valid[1]), 64'd0);
    check_eq("fl_in_ready", 64'(in_ready[1]), 64'd1);
    check_eq("fl_drop_valid", 64'(out_valid[0]), 64'd0);
    out_ready[1] = 1'b1;
    repeat (5) tick();
    check_eq("fl_none_out", 64'(emitted[1] - base[1]), 64'd0);
    check_eq("fl_none_out0", 64'(emitted[0] - base[0]), 64'd0);

    // Mid-stream reset.
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 3; d++) drive(d, 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
      tick();
    end
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      base[d] = emitted[d];
      check_eq($sformatf("d%0d_mrst_valid", d), 64'(out_valid[d]), 64'd0);
      check_eq($sformatf("d%0d_mrst_imm", d), 64'(out_imm[d]), 64'd0);
      check_eq($sformatf("d%0d_mrst_tag", d), 64'(out_tag[d]), 64'd0);
      check_eq($sformatf("d%0d_mrst_err", d), 64'(out_err[d]), 64'd0);
      check_eq($sformatf("d%0d_mrst_ready", d), 64'(in_ready[d]), 64'd1);
    end
    rst_n = 1'b1;
    idle_all();
    repeat (5) tick();
    for (int d = 0; d < 3; d++)
      check_eq($sformatf("d%0d_mrst_stale", d), 64'(emitted[d] - base[d]), 64'd0);

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = ($urandom_range(0, 9) < 7);
        in_ir[d]     = 16'($urandom);
        in_sel[d]    = 3'($urandom_range(0, 7));
        in_tag[d]    = 4'($urandom);
        out_ready[d] = ($urandom_range(0, 9) < 6);
      end
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0;
    for (int d = 0; d < 3; d++) drain(d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
